// File: rtl/cray_mem_pkg.sv
// cray_mem_pkg
// Shared memory-side definitions used by the instruction-fetch responder,
// the instruction buffer and the memory functional unit.
//   - Default widths for word addresses, data words and backing RAM depth.
//   - LATENCY_MAX bounds the responder pipeline depth. It also sizes the
//     in-flight counter.
//   - Word and address typedefs for the default configuration.
package cray_mem_pkg;

  localparam int DEF_ADDR_W     = 22;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_DEPTH_LOG2 = 12;
  localparam int DEF_LATENCY    = 4;
  localparam int LATENCY_MAX    = 16;

  // Wide enough to hold LATENCY_MAX outstanding requests.
  localparam int INFLIGHT_W = $clog2(LATENCY_MAX + 1);

  typedef logic [DEF_ADDR_W-1:0]     mem_addr_t;
  typedef logic [DEF_DATA_W-1:0]     mem_word_t;
  typedef logic [DEF_DEPTH_LOG2-1:0] ram_idx_t;

endpackage

// File: rtl/ifetch_ram.sv
// ifetch_ram
// Backing store for the fetch responder. It is a 1R1W synchronous RAM of
// 2**DEPTH_LOG2 words with a registered read port. The contents are never
// reset.
// Ports:
//   clk        clock
//   wr_en_i    write strobe
//   wr_idx_i   write word index
//   wr_data_i  write data
//   rd_en_i    read strobe; the read register loads only when this is set
//   rd_idx_i   read word index
//   rd_data_o  registered read data, valid the cycle after rd_en_i
module ifetch_ram
  import cray_mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_idx_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  rd_en_i,
  input  logic [DEPTH_LOG2-1:0] rd_idx_i,
  output logic [DATA_W-1:0]     rd_data_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // A read and a write to the same index on one edge forward the write
  // data. An in-flight fetch then always sees the newest word, even when
  // a patch lands on the very edge at which the fetch samples the RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
        rd_data_q <= wr_data_i;
      end else begin
        rd_data_q <= mem_q[rd_idx_i];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ifetch_mem_responder.sv
// ifetch_mem_responder
// Memory-side responder for the instruction-buffer fetch port. Each
// accepted single-word read is acknowledged combinationally. The word is
// returned, in order, exactly LATENCY cycles later from the backing RAM.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   i_mem_read        read request, held by the requester until acked
//   i_mem_addr        word address (upper bits beyond the RAM wrap)
//   o_mem_addr_ack    request accepted this cycle
//   o_mem_data        returned word, zero when o_mem_rd_ack is low
//   o_mem_rd_ack      return strobe, one per accepted request
//   i_bank_busy       stall; blocks acceptance only
//   i_flush           drop every in-flight request
//   i_wr_en           side-port write strobe (takes priority over reads)
//   i_wr_addr         side-port word address
//   i_wr_data         side-port write data
//   o_inflight        accepted requests not yet returned
module ifetch_mem_responder
  import cray_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LATENCY    = DEF_LATENCY,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_read,
  input  logic [ADDR_W-1:0]     i_mem_addr,
  output logic                  o_mem_addr_ack,
  output logic [DATA_W-1:0]     o_mem_data,
  output logic                  o_mem_rd_ack,
  input  logic                  i_bank_busy,
  input  logic                  i_flush,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0]     i_wr_data,
  output logic [INFLIGHT_W-1:0] o_inflight
);

  logic                  ack;
  logic                  kill;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  samp_valid;
  logic [DEPTH_LOG2-1:0] samp_idx;
  logic [DATA_W-1:0]     ram_rd_data;
  logic                  rd_ack_q, rd_ack_d;
  logic [INFLIGHT_W-1:0] inflight_q, inflight_d;
  logic                  unused_addr_hi;

  // The RAM index is the low address bits. The high bits wrap silently.
  assign req_idx        = i_mem_addr[DEPTH_LOG2-1:0];
  assign wr_idx         = i_wr_addr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^{i_mem_addr[ADDR_W-1:DEPTH_LOG2], i_wr_addr[ADDR_W-1:DEPTH_LOG2]};

  // Writes, flush, stall and reset all refuse the request for this cycle.
  // The requester keeps holding it and it is taken on a later cycle.
  assign ack            = i_mem_read & ~i_bank_busy & ~i_wr_en & ~i_flush & ~rst;
  assign o_mem_addr_ack = ack;
  assign kill           = rst | i_flush;

  // The valid/index shift chain has LATENCY-1 stages ahead of the RAM read
  // register. With LATENCY=1 the accepted request feeds the RAM directly.
  // The RAM is sampled only at the end of the chain, so patches that land
  // while a request is travelling are still seen.
  if (LATENCY > 1) begin : g_chain
    localparam int STAGES = LATENCY - 1;

    logic [STAGES-1:0]                 valid_q, valid_d;
    logic [STAGES-1:0][DEPTH_LOG2-1:0] idx_q, idx_d;

    always_comb begin
      valid_d  = '0;
      idx_d    = idx_q;
      idx_d[0] = req_idx;
      for (int s = 1; s < STAGES; s++) begin
        idx_d[s] = idx_q[s-1];
      end
      if (!kill) begin
        valid_d[0] = ack;
        for (int s = 1; s < STAGES; s++) begin
          valid_d[s] = valid_q[s-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end

    assign samp_valid = valid_q[STAGES-1];
    assign samp_idx   = idx_q[STAGES-1];
  end else begin : g_direct
    assign samp_valid = ack;
    assign samp_idx   = req_idx;
  end

  ifetch_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (i_wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i (i_wr_data),
    .rd_en_i   (samp_valid),
    .rd_idx_i  (samp_idx),
    .rd_data_o (ram_rd_data)
  );

  // The return strobe and the outstanding count both clear on flush or
  // reset. A request sitting in the final stage is dropped too, so no
  // return escapes after the kill edge.
  always_comb begin
    rd_ack_d   = samp_valid & ~kill;
    inflight_d = inflight_q;
    if (kill) begin
      inflight_d = '0;
    end else if (ack && !rd_ack_q) begin
      inflight_d = inflight_q + INFLIGHT_W'(1);
    end else if (!ack && rd_ack_q) begin
      inflight_d = inflight_q - INFLIGHT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    rd_ack_q   <= rd_ack_d;
    inflight_q <= inflight_d;
  end

  assign o_mem_rd_ack = rd_ack_q;
  assign o_mem_data   = rd_ack_q ? ram_rd_data : '0;
  assign o_inflight   = inflight_q;

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// tb_ifetch_mem_responder
// Drives two responders (LATENCY=4 and LATENCY=1) from the same inputs.
// A cycle-indexed reference model schedules every accepted request at its
// due cycle and captures the RAM word at the edge before it is due.
module tb_ifetch_mem_responder;

  localparam int AW   = 22;
  localparam int DW   = 64;
  localparam int DL2  = 12;
  localparam int MAXC = 8192;

  logic          clk;
  logic          rst;
  logic          memRead;
  logic [AW-1:0] memAddr;
  logic          bankBusy;
  logic          flush;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;

  logic          ack4, rdAck4, ack1, rdAck1;
  logic [DW-1:0] data4, data1;
  logic [4:0]    infl4, infl1;

  int errors  = 0;
  int checks  = 0;
  bit checkEn = 0;
  int cyc     = 0;

  // Model state: the expected return per instance and per cycle.
  bit            retV   [2][MAXC];
  int            retIdx [2][MAXC];
  logic [DW-1:0] retD   [2][MAXC];
  logic [DW-1:0] memModel [4096];
  int            lat [2] = '{4, 1};

  ifetch_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(4), .DEPTH_LOG2(DL2)) u4 (
    .clk(clk), .rst(rst), .i_mem_read(memRead), .i_mem_addr(memAddr),
    .o_mem_addr_ack(ack4), .o_mem_data(data4), .o_mem_rd_ack(rdAck4),
    .i_bank_busy(bankBusy), .i_flush(flush), .i_wr_en(wrEn),
    .i_wr_addr(wrAddr), .i_wr_data(wrData), .o_inflight(infl4)
  );

  ifetch_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1), .DEPTH_LOG2(DL2)) u1 (
    .clk(clk), .rst(rst), .i_mem_read(memRead), .i_mem_addr(memAddr),
    .o_mem_addr_ack(ack1), .o_mem_data(data1), .o_mem_rd_ack(rdAck1),
    .i_bank_busy(bankBusy), .i_flush(flush), .i_wr_en(wrEn),
    .i_wr_addr(wrAddr), .i_wr_data(wrData), .o_inflight(infl1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Edge-by-edge model. The write lands first. Then flush/reset discard
  // every future return. Then a new acceptance is scheduled. Last, any
  // return due next cycle captures the RAM as it stands after this edge.
  always @(posedge clk) begin : model
    bit accept;
    int due;
    accept = memRead && !bankBusy && !wrEn && !flush && !rst;
    if (wrEn) memModel[wrAddr[DL2-1:0]] = wrData;
    for (int k = 0; k < 2; k++) begin
      if (flush || rst) begin
        for (int d = cyc + 1; d <= cyc + 18; d++) retV[k][d] = 1'b0;
      end
      if (accept) begin
        due            = cyc + lat[k];
        retV[k][due]   = 1'b1;
        retIdx[k][due] = int'(memAddr[DL2-1:0]);
      end
      if (retV[k][cyc+1]) retD[k][cyc+1] = memModel[retIdx[k][cyc+1]];
    end
    cyc = cyc + 1;
  end

  // Compare every output of both instances in the middle of each cycle.
  always @(negedge clk) begin : compare
    logic          expAck;
    logic [DW-1:0] expData;
    int            expInfl;
    string         nm;
    if (checkEn) begin
      expAck = memRead && !bankBusy && !wrEn && !flush && !rst;
      checkOutput("addr_ack_L4", 64'(ack4), 64'(expAck));
      checkOutput("addr_ack_L1", 64'(ack1), 64'(expAck));
      for (int k = 0; k < 2; k++) begin
        nm      = (k == 0) ? "L4" : "L1";
        expInfl = 0;
        for (int d = cyc; d <= cyc + 17; d++) if (retV[k][d]) expInfl++;
        expData = retV[k][cyc] ? retD[k][cyc] : '0;
        checkOutput({"rd_ack_", nm},   64'((k == 0) ? rdAck4 : rdAck1), 64'(retV[k][cyc]));
        checkOutput({"rd_data_", nm},  (k == 0) ? data4 : data1, expData);
        checkOutput({"inflight_", nm}, 64'((k == 0) ? infl4 : infl1), 64'(expInfl));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    memRead  = 1'b0;
    memAddr  = '0;
    bankBusy = 1'b0;
    flush    = 1'b0;
    wrEn     = 1'b0;
    wrAddr   = '0;
    wrData   = '0;
  endtask

  task automatic applyStimulus(input logic rd, input logic [AW-1:0] a, input logic busy,
                               input logic fl, input logic we, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd);
    memRead  = rd;
    memAddr  = a;
    bankBusy = busy;
    flush    = fl;
    wrEn     = we;
    wrAddr   = wa;
    wrData   = wd;
    step();
  endtask

  // Called in the cycle after an acceptance. Counts cycles until the
  // chosen instance returns, bounded so a missing return cannot hang.
  task automatic waitReturn(input string name, input bit useL1, input logic [DW-1:0] expData,
                            input int expLat);
    int   n;
    logic got;
    setIdle();
    n   = 1;
    got = useL1 ? rdAck1 : rdAck4;
    while (!got && n <= 20) begin
      step();
      n++;
      got = useL1 ? rdAck1 : rdAck4;
    end
    checkOutput({name, "_latency"}, 64'(n), 64'(expLat));
    checkOutput({name, "_data"}, useL1 ? data1 : data4, expData);
  endtask

  initial begin : stimulus
    int            cur;
    bit            pending;
    bit            busyV, flV, weV;
    logic [AW-1:0] pendAddr;
    logic [AW-1:0] wa;

    setIdle();
    rst = 1'b1;
    step();
    checkEn = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("reset_inflight", 64'(infl4), 64'd0);
    checkOutput("reset_rd_ack", 64'(rdAck4), 64'd0);
    checkOutput("reset_data", data4, 64'd0);

    // Preload the first 64 words with A000+i.
    for (int i = 0; i < 64; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(i), 64'hA000 + 64'(i));
    setIdle();
    step();

    // Full-throughput stream over addresses 0..15.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, AW'(i), 1'b0, 1'b0, 1'b0, '0, '0);
    setIdle();
    for (int i = 0; i < 6; i++) step();

    // LATENCY=1 single read: the return arrives the very next cycle.
    applyStimulus(1'b1, AW'(5), 1'b0, 1'b0, 1'b0, '0, '0);
    waitReturn("l1_single", 1'b1, 64'hA005, 1);
    checkOutput("l1_inflight_hi", 64'(infl1), 64'd1);
    step();
    checkOutput("l1_inflight_lo", 64'(infl1), 64'd0);
    for (int i = 0; i < 5; i++) step();

    // Stream over 16..31 with a 3-cycle stall in the middle.
    cur = 16;
    for (int k = 0; k < 40 && cur < 32; k++) begin
      busyV = (k >= 4 && k < 7);
      applyStimulus(1'b1, AW'(cur), busyV, 1'b0, 1'b0, '0, '0);
      if (!busyV) cur++;
    end
    setIdle();
    for (int i = 0; i < 6; i++) step();

    // Flush with two requests in flight and a third held across the flush.
    applyStimulus(1'b1, AW'('h20), 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, AW'('h21), 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, AW'('h22), 1'b0, 1'b1, 1'b0, '0, '0);
    checkOutput("flush_inflight_L4", 64'(infl4), 64'd0);
    checkOutput("flush_inflight_L1", 64'(infl1), 64'd0);
    applyStimulus(1'b1, AW'('h22), 1'b0, 1'b0, 1'b0, '0, '0);
    waitReturn("post_flush", 1'b0, 64'hA022, 4);
    for (int i = 0; i < 3; i++) step();

    // A write in the same cycle blocks the read. The retried read sees the
    // new word.
    memRead = 1'b1; memAddr = AW'(7);
    wrEn = 1'b1; wrAddr = AW'(7); wrData = 64'hDEAD_BEEF_0000_0001;
    #1;
    checkOutput("wr_blocks_ack", 64'(ack4), 64'd0);
    step();
    applyStimulus(1'b1, AW'(7), 1'b0, 1'b0, 1'b0, '0, '0);
    waitReturn("wr_then_rd", 1'b0, 64'hDEAD_BEEF_0000_0001, 4);
    for (int i = 0; i < 3; i++) step();

    // A patch that lands while the read of the same word is in flight.
    applyStimulus(1'b1, AW'(7), 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(7), 64'hDEAD_BEEF_0000_0002);
    waitReturn("inflight_wr", 1'b0, 64'hDEAD_BEEF_0000_0002, 2);
    for (int i = 0; i < 3; i++) step();

    // The high address bits wrap onto the RAM.
    applyStimulus(1'b1, 22'h3F_F003, 1'b0, 1'b0, 1'b0, '0, '0);
    waitReturn("wrap_addr", 1'b0, 64'hA003, 4);
    for (int i = 0; i < 3; i++) step();

    // Reset with three requests in flight.
    applyStimulus(1'b1, AW'(1), 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, AW'(2), 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, AW'(3), 1'b0, 1'b0, 1'b0, '0, '0);
    setIdle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_drop_rd_ack", 64'(rdAck4), 64'd0);
    checkOutput("rst_drop_inflight", 64'(infl4), 64'd0);
    checkOutput("rst_drop_data", data4, 64'd0);
    for (int i = 0; i < 6; i++) step();

    // Random traffic: held requests, stalls, flushes, patches, resets.
    pending = 1'b0;
    pendAddr = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!pending && $urandom_range(0, 99) < 60) begin
        pending = 1'b1;
        pendAddr = AW'($urandom());
        pendAddr[DL2-1:0] = DL2'($urandom_range(0, 63));
      end
      busyV = ($urandom_range(0, 99) < 20);
      flV   = ($urandom_range(0, 99) < 3);
      weV   = ($urandom_range(0, 99) < 10);
      wa    = AW'($urandom());
      wa[DL2-1:0] = DL2'($urandom_range(0, 63));
      rst   = ($urandom_range(0, 199) == 0);
      if (pending && !busyV && !flV && !weV && !rst) begin
        applyStimulus(1'b1, pendAddr, busyV, flV, weV, wa, {$urandom(), $urandom()});
        pending = 1'b0;
      end else begin
        applyStimulus(pending, pendAddr, busyV, flV, weV, wa, {$urandom(), $urandom()});
      end
    end
    rst = 1'b0;
    setIdle();
    for (int i = 0; i < 20; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
